// File: rtl/fifo_wr_ctrl_if.sv
// Write-side bus of the dual-clock FIFO: client request/status plus the
// pointer exchanged with the read-side controller.
interface fifo_wr_ctrl_if #(
    parameter int ADDRSIZE = 4
);
    logic                i_wr_en;
    logic [ADDRSIZE:0]   i_rd_ptr_gray;
    logic [ADDRSIZE:0]   i_afull_thresh;
    logic                i_ovf_clr;
    logic [ADDRSIZE-1:0] o_wr_addr;
    logic                o_wr_en_ram;
    logic [ADDRSIZE:0]   o_wr_ptr;
    logic                o_full;
    logic                o_almost_full;
    logic [ADDRSIZE:0]   o_wr_level;
    logic                o_wr_ack;
    logic                o_overflow;

    modport master (
        output i_wr_en, i_rd_ptr_gray, i_afull_thresh, i_ovf_clr,
        input  o_wr_addr, o_wr_en_ram, o_wr_ptr, o_full, o_almost_full,
               o_wr_level, o_wr_ack, o_overflow
    );

    modport slave (
        input  i_wr_en, i_rd_ptr_gray, i_afull_thresh, i_ovf_clr,
        output o_wr_addr, o_wr_en_ram, o_wr_ptr, o_full, o_almost_full,
               o_wr_level, o_wr_ack, o_overflow
    );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// Write-domain controller of the dual-clock FIFO: binary/Gray write pointer,
// read-pointer synchroniser, full / almost-full / level / ack / overflow.
module fifo_wr_ctrl #(
    parameter int ADDRSIZE    = 4,   // depth = 2**ADDRSIZE, 2..12
    parameter int SYNC_STAGES = 2    // 2..4
) (
    input  logic          i_wr_clk,
    input  logic          i_wr_rst_n,
    fifo_wr_ctrl_if.slave wr
);
    localparam logic [ADDRSIZE:0] DEPTH = {1'b1, {ADDRSIZE{1'b0}}};

    logic [SYNC_STAGES-1:0][ADDRSIZE:0] sync_q;
    logic [ADDRSIZE:0] rq, rd_bin;
    logic [ADDRSIZE:0] wr_bin, ptr_q, lvl_q;
    logic [ADDRSIZE:0] bin_next, gray_next, lvl_next, full_cmp;
    logic              accept;
    logic              full_q, afull_q, ack_q, ovf_q;

    // Plain flop chain; nothing may sit between stages.
    always_ff @(posedge i_wr_clk or negedge i_wr_rst_n) begin
        if (!i_wr_rst_n) sync_q <= '0;
        else             sync_q <= {sync_q[SYNC_STAGES-2:0], wr.i_rd_ptr_gray};
    end

    assign rq = sync_q[SYNC_STAGES-1];

    // Gray to binary: bit i is the XOR of rq[ADDRSIZE:i].
    always_comb begin
        rd_bin = '0;
        for (int i = 0; i <= ADDRSIZE; i++) rd_bin[i] = ^(rq >> i);
    end

    assign accept    = wr.i_wr_en & ~full_q;
    assign bin_next  = wr_bin + {{ADDRSIZE{1'b0}}, accept};
    assign gray_next = (bin_next >> 1) ^ bin_next;
    assign lvl_next  = bin_next - rd_bin;
    // Write pointer is exactly one lap ahead of the synchronised read pointer.
    assign full_cmp  = {~rq[ADDRSIZE:ADDRSIZE-1], rq[ADDRSIZE-2:0]};

    always_ff @(posedge i_wr_clk or negedge i_wr_rst_n) begin
        if (!i_wr_rst_n) begin
            wr_bin  <= '0;
            ptr_q   <= '0;
            lvl_q   <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            ack_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wr_bin  <= bin_next;
            ptr_q   <= gray_next;
            lvl_q   <= lvl_next;
            full_q  <= (gray_next == full_cmp);
            afull_q <= (lvl_next >= wr.i_afull_thresh);
            ack_q   <= accept;
            // Set has priority over clear.
            if (wr.i_wr_en & full_q) ovf_q <= 1'b1;
            else if (wr.i_ovf_clr)   ovf_q <= 1'b0;
        end
    end

    assign wr.o_wr_addr     = wr_bin[ADDRSIZE-1:0];
    assign wr.o_wr_en_ram   = accept;
    assign wr.o_wr_ptr      = ptr_q;
    assign wr.o_full        = full_q;
    assign wr.o_almost_full = afull_q;
    assign wr.o_wr_level    = lvl_q;
    assign wr.o_wr_ack      = ack_q;
    assign wr.o_overflow    = ovf_q;

    a_gray_step: assert property (@(posedge i_wr_clk) disable iff (!i_wr_rst_n)
        $countones(ptr_q ^ $past(ptr_q)) <= 1);
    a_level_max: assert property (@(posedge i_wr_clk) disable iff (!i_wr_rst_n)
        lvl_q <= DEPTH);
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Random write/read traffic on two controller configurations, checked against
// a word-count model with an explicit read-pointer visibility delay.
module tb_fifo_wr_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_ctrl_if #(.ADDRSIZE(4)) ba ();
  fifo_wr_ctrl_if #(.ADDRSIZE(3)) bb ();

  fifo_wr_ctrl #(.ADDRSIZE(4), .SYNC_STAGES(2)) u_a (.i_wr_clk(clk), .i_wr_rst_n(rst_n), .wr(ba));
  fifo_wr_ctrl #(.ADDRSIZE(3), .SYNC_STAGES(3)) u_b (.i_wr_clk(clk), .i_wr_rst_n(rst_n), .wr(bb));

  int total = 0;
  int bad = 0;

  int aw[2] = '{4, 3};
  int ss[2] = '{2, 3};
  int wcnt[2], rcnt[2], th[2];
  int full_m[2], ovf_m[2], ack_m[2], lvl_m[2], af_m[2];
  int hist[2][8];
  logic en[2], clr[2];

  int pw[6] = '{90, 60, 30, 95, 70, 85};
  int pr[6] = '{5, 60, 80, 30, 50, 20};
  int pc[6] = '{10, 5, 20, 10, 5, 10};

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int gray(int b);
    return b ^ (b >> 1);
  endfunction

  function automatic int depth(int d);
    return 1 << aw[d];
  endfunction

  task automatic apply(int d);
    if (d == 0) begin
      ba.i_wr_en        = en[0];
      ba.i_ovf_clr      = clr[0];
      ba.i_rd_ptr_gray  = 5'(gray(rcnt[0] % 32));
      ba.i_afull_thresh = 5'(th[0]);
    end else begin
      bb.i_wr_en        = en[1];
      bb.i_ovf_clr      = clr[1];
      bb.i_rd_ptr_gray  = 4'(gray(rcnt[1] % 16));
      bb.i_afull_thresh = 4'(th[1]);
    end
  endtask

  task automatic sample(int d, output logic [31:0] addr, ram, ptr, full, af, lvl, ack, ovf);
    if (d == 0) begin
      addr = 32'(ba.o_wr_addr); ram = 32'(ba.o_wr_en_ram); ptr = 32'(ba.o_wr_ptr);
      full = 32'(ba.o_full); af = 32'(ba.o_almost_full); lvl = 32'(ba.o_wr_level);
      ack = 32'(ba.o_wr_ack); ovf = 32'(ba.o_overflow);
    end else begin
      addr = 32'(bb.o_wr_addr); ram = 32'(bb.o_wr_en_ram); ptr = 32'(bb.o_wr_ptr);
      full = 32'(bb.o_full); af = 32'(bb.o_almost_full); lvl = 32'(bb.o_wr_level);
      ack = 32'(bb.o_wr_ack); ovf = 32'(bb.o_overflow);
    end
  endtask

  task automatic check_regs(int d);
    logic [31:0] addr, ram, ptr, full, af, lvl, ack, ovf;
    sample(d, addr, ram, ptr, full, af, lvl, ack, ovf);
    check($sformatf("ptr%0d", d),   ptr,  32'(gray(wcnt[d] % (2 * depth(d)))));
    check($sformatf("full%0d", d),  full, 32'(full_m[d]));
    check($sformatf("afull%0d", d), af,   32'(af_m[d]));
    check($sformatf("level%0d", d), lvl,  32'(lvl_m[d]));
    check($sformatf("ack%0d", d),   ack,  32'(ack_m[d]));
    check($sformatf("ovf%0d", d),   ovf,  32'(ovf_m[d]));
  endtask

  task automatic check_comb(int d);
    logic [31:0] addr, ram, ptr, full, af, lvl, ack, ovf;
    sample(d, addr, ram, ptr, full, af, lvl, ack, ovf);
    check($sformatf("ram_we%0d", d), ram,  32'(en[d] && full_m[d] == 0));
    check($sformatf("addr%0d", d),   addr, 32'(wcnt[d] % depth(d)));
  endtask

  // One clock edge of the model: level is measured against the read count
  // that was driven SYNC_STAGES cycles before this edge.
  task automatic model_edge(int d);
    int acc;
    acc = (en[d] && full_m[d] == 0) ? 1 : 0;
    if (en[d] && full_m[d] != 0) ovf_m[d] = 1;
    else if (clr[d])            ovf_m[d] = 0;
    ack_m[d]  = acc;
    wcnt[d]  += acc;
    lvl_m[d]  = wcnt[d] - hist[d][ss[d]];
    full_m[d] = (lvl_m[d] == depth(d)) ? 1 : 0;
    af_m[d]   = (lvl_m[d] >= th[d]) ? 1 : 0;
    for (int k = 7; k > 0; k--) hist[d][k] = hist[d][k-1];
  endtask

  task automatic model_clear(int d);
    wcnt[d] = 0; rcnt[d] = 0; full_m[d] = 0; ovf_m[d] = 0;
    ack_m[d] = 0; lvl_m[d] = 0; af_m[d] = 0;
    for (int k = 0; k < 8; k++) hist[d][k] = 0;
    en[d] = 1'b0; clr[d] = 1'b0;
  endtask

  // Entered and left at a falling edge.
  task automatic step(int p);
    for (int d = 0; d < 2; d++) check_regs(d);
    for (int d = 0; d < 2; d++) begin
      en[d]  = ($urandom_range(99) < pw[p]);
      clr[d] = ($urandom_range(99) < pc[p]);
      if (rcnt[d] < wcnt[d] && $urandom_range(99) < pr[p]) rcnt[d]++;
      hist[d][0] = rcnt[d];
      apply(d);
    end
    #1;
    for (int d = 0; d < 2; d++) check_comb(d);
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_edge(d);
    @(negedge clk);
  endtask

  task automatic do_reset();
    for (int d = 0; d < 2; d++) begin
      model_clear(d);
      th[d] = 1 + $urandom_range(depth(d) - 1);
      apply(d);
    end
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check_regs(d);
      check_comb(d);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    for (int p = 0; p < 6; p++) begin
      for (int d = 0; d < 2; d++) begin
        if (p == 3)      th[d] = 0;
        else if (p == 4) th[d] = depth(d) + 1 + $urandom_range(depth(d) - 2);
        else             th[d] = 1 + $urandom_range(depth(d) - 1);
      end
      for (int c = 0; c < 400; c++) begin
        step(p);
        if ((p == 1 || p == 3) && c == 200) do_reset();
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
